// File: rtl/ap_ctrl_multi_monitor.sv
// ap_ctrl_multi_monitor: per-channel ap_ctrl_hs/ap_ctrl_chain handshake statistics
// (count, busy, stall, latency, interval) with a registered read-select port.
`default_nettype none

module ap_ctrl_multi_monitor #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic [SEL_W-1:0]  rd_ch,
  input  logic [2:0]        rd_field,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    WAIT_CONT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [CNT_W-1:0] txn_a      [NUM_CH];
  logic [CNT_W-1:0] busy_a     [NUM_CH];
  logic [CNT_W-1:0] last_lat_a [NUM_CH];
  logic [CNT_W-1:0] min_lat_a  [NUM_CH];
  logic [CNT_W-1:0] max_lat_a  [NUM_CH];
  logic [CNT_W-1:0] last_int_a [NUM_CH];
  logic [CNT_W-1:0] stall_a    [NUM_CH];
  logic [CNT_W-1:0] f7_a       [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic             accept, complete, in_busy, sat, ovf_q;
    logic [CNT_W-1:0] latency, lat_cnt, int_cnt;
    logic [CNT_W-1:0] txn, busy_c, stall, ready_c, last_lat, min_lat, max_lat, last_int;

    always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      complete = 1'b0;
      latency  = '0;
      case (state_q)
        IDLE: begin
          if (ap_start[c]) begin
            accept = 1'b1;
            if (ap_done[c]) begin
              complete = 1'b1;
              latency  = CNT_ONE;
              state_d  = ap_continue[c] ? IDLE : WAIT_CONT;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (ap_done[c]) begin
            complete = 1'b1;
            latency  = sat_inc(lat_cnt);
            state_d  = ap_continue[c] ? IDLE : WAIT_CONT;
          end
        end
        WAIT_CONT: begin
          if (ap_continue[c]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    assign in_busy = accept || (state_q == BUSY);
    // Any counter that would step past all-ones this cycle flags saturation.
    assign sat = (complete && txn == CNT_MAX)
              || (in_busy && busy_c == CNT_MAX)
              || (in_busy && ap_ready[c] && ready_c == CNT_MAX)
              || (state_q == WAIT_CONT && stall == CNT_MAX)
              || (state_q == BUSY && lat_cnt == CNT_MAX)
              || (!accept && int_cnt == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)     state_q <= IDLE;
      else if (clear) state_q <= IDLE;
      else            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset || clear) begin
        lat_cnt  <= '0;
        int_cnt  <= '0;
        txn      <= '0;
        busy_c   <= '0;
        stall    <= '0;
        ready_c  <= '0;
        last_lat <= '0;
        min_lat  <= CNT_MAX;
        max_lat  <= '0;
        last_int <= '0;
        ovf_q    <= 1'b0;
      end else begin
        // Latency and interval timers keep running through a freeze so the
        // values recorded afterwards are the true ones.
        if (accept)                lat_cnt <= CNT_ONE;
        else if (state_q == BUSY)  lat_cnt <= sat_inc(lat_cnt);
        if (accept)                int_cnt <= CNT_ONE;
        else if (int_cnt != '0)    int_cnt <= sat_inc(int_cnt);
        if (!finish) begin
          if (accept && int_cnt != '0)     last_int <= int_cnt;
          if (in_busy)                     busy_c   <= sat_inc(busy_c);
          if (in_busy && ap_ready[c])      ready_c  <= sat_inc(ready_c);
          if (state_q == WAIT_CONT)        stall    <= sat_inc(stall);
          if (complete) begin
            txn      <= sat_inc(txn);
            last_lat <= latency;
            if (latency < min_lat) min_lat <= latency;
            if (latency > max_lat) max_lat <= latency;
          end
          if (sat) ovf_q <= 1'b1;
        end
      end
    end

    assign txn_a[c]      = txn;
    assign busy_a[c]     = busy_c;
    assign last_lat_a[c] = last_lat;
    assign min_lat_a[c]  = min_lat;
    assign max_lat_a[c]  = max_lat;
    assign last_int_a[c] = last_int;
    assign stall_a[c]    = stall;
    assign f7_a[c]       = {ready_c[CNT_W-3:0], state_q};
    assign ovf[c]        = ovf_q;
  end

  logic [CNT_W-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == SEL_W'(c)) begin
        case (rd_field)
          3'd0:    rd_next = txn_a[c];
          3'd1:    rd_next = busy_a[c];
          3'd2:    rd_next = last_lat_a[c];
          3'd3:    rd_next = min_lat_a[c];
          3'd4:    rd_next = max_lat_a[c];
          3'd5:    rd_next = last_int_a[c];
          3'd6:    rd_next = stall_a[c];
          default: rd_next = f7_a[c];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (clear) rd_data <= '0;
    else            rd_data <= rd_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_multi_monitor.sv
// Bench for ap_ctrl_multi_monitor: directed scenarios plus random traffic checked
// against a timestamp-based reference model; a narrow-counter instance covers saturation.
`default_nettype none

module tb_ap_ctrl_multi_monitor;
  localparam int NCH = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic           finish, clear;
  logic [3:0]     rd_ch;
  logic [2:0]     rd_field;
  logic [31:0]    rd_data;
  logic [NCH-1:0] ovf;
  logic [3:0]     rd_data4;
  logic [NCH-1:0] ovf4;

  always #5 clock = ~clock;

  ap_ctrl_multi_monitor #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data), .ovf(ovf));

  ap_ctrl_multi_monitor #(.NUM_CH(NCH), .CNT_W(4), .SEL_W(4)) dut4 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data4), .ovf(ovf4));

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  longint t = 0;

  // Reference model: transactions tracked by accept timestamps.
  bit     m_busy [NCH];
  bit     m_wait [NCH];
  longint m_tacc [NCH];
  longint m_tprev[NCH];
  longint m_txn[NCH], m_bc[NCH], m_st[NCH], m_rdy[NCH];
  longint m_last[NCH], m_min[NCH], m_max[NCH], m_lint[NCH];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 0; m_wait[c] = 0; m_tacc[c] = 0; m_tprev[c] = -1;
      m_txn[c] = 0; m_bc[c] = 0; m_st[c] = 0; m_rdy[c] = 0;
      m_last[c] = 0; m_min[c] = 64'd4294967295; m_max[c] = 0; m_lint[c] = 0;
    end
  endfunction

  function automatic void complete(input int c, input longint lat, input bit frz);
    m_busy[c] = 0;
    if (!frz) begin
      m_txn[c]++;
      m_last[c] = lat;
      if (lat < m_min[c]) m_min[c] = lat;
      if (lat > m_max[c]) m_max[c] = lat;
    end
    m_wait[c] = !ap_continue[c];
  endfunction

  function automatic void model_step();
    bit frz;
    frz = finish;
    if (clear) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (m_busy[c]) begin
        if (!frz) begin
          m_bc[c]++;
          if (ap_ready[c]) m_rdy[c]++;
        end
        if (ap_done[c]) complete(c, t - m_tacc[c] + 1, frz);
      end else if (m_wait[c]) begin
        if (!frz) m_st[c]++;
        if (ap_continue[c]) m_wait[c] = 0;
      end else if (ap_start[c]) begin
        if (!frz) begin
          m_bc[c]++;
          if (ap_ready[c]) m_rdy[c]++;
          if (m_tprev[c] >= 0) m_lint[c] = t - m_tprev[c];
        end
        m_tprev[c] = t;
        if (ap_done[c]) complete(c, 1, frz);
        else begin
          m_busy[c] = 1;
          m_tacc[c] = t;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_field(input logic [3:0] ch, input logic [2:0] f);
    logic [31:0] r;
    logic [1:0]  st;
    int          c;
    if (ch >= 4'(NCH)) return 32'd0;
    c  = int'(ch);
    st = m_busy[c] ? 2'd1 : (m_wait[c] ? 2'd2 : 2'd0);
    r  = m_rdy[c][31:0];
    case (f)
      3'd0:    return m_txn[c][31:0];
      3'd1:    return m_bc[c][31:0];
      3'd2:    return m_last[c][31:0];
      3'd3:    return m_min[c][31:0];
      3'd4:    return m_max[c][31:0];
      3'd5:    return m_lint[c][31:0];
      3'd6:    return m_st[c][31:0];
      default: return {r[29:0], st};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    ap_start = '0; ap_done = '0; ap_ready = '0; ap_continue = '1;
    finish = 1'b0; clear = 1'b0;
  endtask

  // One clock with the inputs currently driven; checks the read port against the model.
  task automatic cyc();
    logic [31:0] e;
    e = clear ? 32'd0 : exp_field(rd_ch, rd_field);
    model_step();
    @(posedge clock);
    #1;
    t++;
    chk("rd_data", rd_data, e);
    chk("ovf", {29'd0, ovf}, 32'd0);
  endtask

  task automatic rd(input logic [3:0] ch, input logic [2:0] f, input logic [31:0] e, input string tag);
    set_idle();
    rd_ch = ch; rd_field = f;
    cyc();
    chk(tag, rd_data, e);
  endtask

  task automatic rd4(input logic [3:0] ch, input logic [2:0] f, input logic [3:0] e, input string tag);
    set_idle();
    rd_ch = ch; rd_field = f;
    cyc();
    chk(tag, {28'd0, rd_data4}, {28'd0, e});
  endtask

  initial begin
    bit frz_r;
    reset = 1'b0;
    set_idle();
    rd_ch = '0; rd_field = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ovf", {29'd0, ovf}, 32'd0);
    reset = 1'b1;
    rd(0, 3, 32'hFFFF_FFFF, "rst_min_lat");
    rd(0, 0, 32'd0, "rst_txn");
    rd(2, 7, 32'd0, "rst_state");

    // Single transaction on ch0: accept, three BUSY cycles, done.
    set_idle(); ap_start[0] = 1'b1; ap_ready[0] = 1'b1; cyc();
    set_idle(); repeat (3) cyc();
    ap_done[0] = 1'b1; cyc();
    rd(0, 0, 32'd1, "t1_txn");
    rd(0, 2, 32'd5, "t1_last_lat");
    rd(0, 3, 32'd5, "t1_min_lat");
    rd(0, 4, 32'd5, "t1_max_lat");
    rd(0, 1, 32'd5, "t1_busy");
    rd(0, 7, 32'd4, "t1_ready_state");

    // ch1: combinational block, two transactions 3 cycles apart.
    set_idle(); ap_start[1] = 1'b1; ap_done[1] = 1'b1; cyc();
    set_idle(); cyc(); cyc();
    ap_start[1] = 1'b1; ap_done[1] = 1'b1; cyc();
    rd(1, 5, 32'd3, "t2_last_int");
    rd(1, 2, 32'd1, "t2_last_lat");
    rd(1, 1, 32'd2, "t2_busy");
    rd(1, 0, 32'd2, "t2_txn");

    // ch2: continue held low 4 cycles; starts during WAIT_CONT are ignored.
    set_idle(); ap_start[2] = 1'b1; cyc();
    set_idle(); ap_done[2] = 1'b1; ap_continue[2] = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin
      set_idle(); ap_continue[2] = 1'b0; ap_start[2] = 1'b1; cyc();
    end
    set_idle(); cyc();
    rd(2, 6, 32'd4, "t3_stall");
    rd(2, 0, 32'd1, "t3_txn");
    rd(2, 7, 32'd0, "t3_state");

    rd(1, 4, 32'd1, "rp_max_lat1");
    rd(7, 0, 32'd0, "rp_oor_txn");
    rd(7, 4, 32'd0, "rp_oor_max");

    // Freeze mid-BUSY on ch0: accept 0, finish 2..5, done 7.
    for (int k = 0; k < 8; k++) begin
      set_idle(); rd_ch = 4'd0; rd_field = 3'd1;
      ap_start[0] = (k == 0);
      finish      = (k >= 2 && k <= 5);
      ap_done[0]  = (k == 7);
      cyc();
      if (k >= 3 && k <= 6) chk("frz_busy_hold", rd_data, 32'd7);
    end
    rd(0, 2, 32'd8, "frz_last_lat");
    rd(0, 1, 32'd9, "frz_busy");
    rd(0, 4, 32'd8, "frz_max_lat");
    rd(0, 3, 32'd5, "frz_min_lat");

    // Asynchronous reset while ch0 is BUSY.
    set_idle(); ap_start[0] = 1'b1; cyc();
    set_idle(); rd_ch = 4'd0; rd_field = 3'd0; cyc();
    chk("pre_rst_txn", rd_data, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_rd_data", rd_data, 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    rd(0, 7, 32'd0, "arst_state");
    rd(0, 0, 32'd0, "arst_txn");
    rd(0, 1, 32'd0, "arst_busy");
    rd(0, 3, 32'hFFFF_FFFF, "arst_min_lat");

    // Random traffic against the model.
    frz_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        ap_start[c]    = ($urandom_range(0, 2) == 0);
        ap_done[c]     = ($urandom_range(0, 2) == 0);
        ap_continue[c] = ($urandom_range(0, 2) != 0);
        ap_ready[c]    = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 19) == 0) frz_r = ~frz_r;
      finish   = frz_r;
      clear    = ($urandom_range(0, 499) == 0);
      rd_ch    = 4'($urandom_range(0, 4));
      rd_field = 3'($urandom_range(0, 7));
      cyc();
    end

    // Narrow-counter instance: saturation and clear.
    set_idle(); clear = 1'b1; cyc();
    for (int k = 0; k < 20; k++) begin
      set_idle(); ap_start[0] = 1'b1; ap_done[0] = 1'b1; cyc();
      set_idle(); cyc();
    end
    rd4(0, 0, 4'd15, "sat_txn");
    chk("sat_ovf", {29'd0, ovf4}, 32'd1);
    rd4(0, 1, 4'd15, "sat_busy");
    rd4(0, 2, 4'd1, "sat_last_lat");
    rd4(0, 5, 4'd2, "sat_last_int");
    rd4(1, 0, 4'd0, "sat_other_txn");
    set_idle(); clear = 1'b1; cyc();
    chk("clr_ovf", {29'd0, ovf4}, 32'd0);
    rd4(0, 0, 4'd0, "clr_txn");
    rd4(0, 3, 4'd15, "clr_min_lat");
    rd4(0, 1, 4'd0, "clr_busy");
    rd4(0, 4, 4'd0, "clr_max_lat");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
